// File: rtl/image_mem_reader.sv
// ---------------------------------------------------------------------------
// image_mem_reader
//
// Streams a block of bytes out of a single-read-port image memory. When start
// is accepted in IDLE it latches base_addr/length. It issues one read per
// cycle while the read pipeline has room. Each returned byte passes through a
// 2-entry skid FIFO, and the FIFO head drives a valid/ready pixel port.
//
// Optional feature: define IMG_READER_CHECKSUM_EN to add the checksum output.
// This output is the modulo-2^16 sum of the accepted pixels of the current
// transfer.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : synchronous, active-high reset
//   start      : request a transfer (only looked at in IDLE)
//   base_addr  : first byte address (18 bit)
//   length     : byte count (18 bit)
//   mem_a      : read address to the image memory controller
//   mem_we     : write enable, tied low
//   mem_wd     : write data, tied low
//   mem_rd     : read data, valid one cycle after mem_a
//   px_data    : streamed pixel
//   px_valid   : px_data holds a pixel
//   px_ready   : consumer accepts the pixel
//   busy       : high in any state other than IDLE
//   done       : one-cycle pulse when a transfer completes
//   err        : one-cycle pulse after a start with an out-of-range base
//   checksum   : (IMG_READER_CHECKSUM_EN only) running pixel sum
// ---------------------------------------------------------------------------
module image_mem_reader #(
  parameter int unsigned MEM_DEPTH  = 160000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [17:0] base_addr,
  input  logic [17:0] length,
  output logic [17:0] mem_a,
  output logic        mem_we,
  output logic [7:0]  mem_wd,
  input  logic [7:0]  mem_rd,
  output logic [7:0]  px_data,
  output logic        px_valid,
  input  logic        px_ready,
  output logic        busy,
  output logic        done,
  output logic        err
`ifdef IMG_READER_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_e;

  localparam logic [18:0] MEM_DEPTH_W = 19'(MEM_DEPTH);
  localparam logic [2:0]  FIFO_LIMIT  = 3'(FIFO_DEPTH);

  state_e      state_q, state_d;
  logic [17:0] base_q, len_q, idx_q, mem_a_q;
  logic        pend_q;          // a read was issued last cycle; its data is on mem_rd now
  logic        err_q;
  logic [1:0]  cnt_q;           // FIFO occupancy
  logic [7:0]  head_q, tail_q;  // head_q is the registered FIFO output

  logic        addr_ok, start_acc, pop, push, issue, last_issue;
  logic [2:0]  level;
  logic [18:0] addr_sum;
  logic [17:0] rd_addr;

  assign addr_ok    = {1'b0, base_addr} < MEM_DEPTH_W;
  assign start_acc  = (state_q == S_IDLE) && start && addr_ok;
  assign px_valid   = (cnt_q != 2'd0);
  assign px_data    = head_q;
  assign pop        = px_valid && px_ready;
  assign push       = pend_q;

  // The level counts bytes already buffered and bytes still on the way.
  // A pop in the same cycle frees a slot, so it is subtracted. The pop term
  // keeps throughput at one read per cycle despite the two-cycle round trip.
  assign level      = 3'(cnt_q) + 3'(pend_q) - 3'(pop);
  assign issue      = (state_q == S_READ) && (level < FIFO_LIMIT);
  assign last_issue = (idx_q == len_q - 18'd1);

  // Single conditional subtract in 19 bits wraps the address back to 0.
  assign addr_sum   = {1'b0, base_q} + {1'b0, idx_q};
  assign rd_addr    = 18'((addr_sum >= MEM_DEPTH_W) ? addr_sum - MEM_DEPTH_W : addr_sum);

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // flop samples pre-edge values, independent of process ordering.
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first, so no path leaves state_d unassigned
    // (which would infer a latch).
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && addr_ok) state_d = (length == 18'd0) ? S_DONE : S_READ;
      S_READ:  if (issue && last_issue) state_d = S_DRAIN;
      // Leave once nothing is in flight and the last buffered byte is
      // either gone already or being accepted right now.
      S_DRAIN: if (!pend_q && (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop))) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy  = (state_q != S_IDLE);
    done  = (state_q == S_DONE);
    mem_a = 18'd0;
    if (state_q != S_IDLE) mem_a = issue ? rd_addr : mem_a_q;
  end

  assign mem_we = 1'b0;
  assign mem_wd = 8'd0;
  assign err    = err_q;

  // Read issue, in-flight tracking and the 2-entry skid FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the FIFO storage is reset too. px_data is required to read 0
      // after reset, and only two bytes are involved.
      base_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      mem_a_q <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      err_q <= (state_q == S_IDLE) && start && !addr_ok;
      if (start_acc) begin
        base_q  <= base_addr;
        len_q   <= length;
        idx_q   <= '0;
        mem_a_q <= '0;
      end
      if (issue) begin
        idx_q   <= idx_q + 18'd1;
        mem_a_q <= rd_addr;
      end
      pend_q <= issue;

      case (cnt_q)
        2'd0: if (push) begin
          head_q <= mem_rd;
          cnt_q  <= 2'd1;
        end
        2'd1: begin
          if (push && pop)  head_q <= mem_rd;
          else if (push) begin
            tail_q <= mem_rd;
            cnt_q  <= 2'd2;
          end else if (pop) cnt_q <= 2'd0;
        end
        // Full: the issue throttle guarantees no push arrives without a pop.
        default: if (pop) begin
          head_q <= tail_q;
          if (push) tail_q <= mem_rd;
          else      cnt_q  <= 2'd1;
        end
      endcase
    end
  end

`ifdef IMG_READER_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clk) begin
    if (reset)          sum_q <= '0;
    else if (start_acc) sum_q <= '0;
    else if (pop)       sum_q <= sum_q + {8'd0, px_data};
  end

  assign checksum = sum_q;
`endif

endmodule
